uart_rx_param: RTL and testbench

Parametrised RS-232 receiver. Successor to the fixed 8N1 receiver. Data width, parity mode and stop-bit count are set by parameters. Adds an input synchroniser, start-bit validation, and parity/framing error reporting. Sits between the board rx pin and the byte-level consumers (loopback, command parser).

---
 rtl/uart_rx_param.sv | 182 ++++++++++++++++++
 tb/tb_uart_rx_param.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised RS-232 receiver with parity and framing checks
// Synchronised input, mid-bit sampling, one-cycle po_flag per completed frame.
module uart_rx_param #(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 system_clk,
  input  logic                 system_rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] po_data,
  output logic                 po_flag,
  output logic                 po_parity_err,
  output logic                 po_frame_err,
  output logic                 busy
);

  localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
  localparam int HALF         = BAUD_CNT_MAX / 2;
  localparam int CW           = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;

  localparam logic [CW-1:0] C_LAST      = CW'(BAUD_CNT_MAX - 1);
  localparam logic [CW-1:0] C_HALF      = CW'(HALF);
  localparam logic [3:0]    C_DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    C_STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          C_ODD       = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   w_done;

  logic                   r_rx_meta;
  logic                   r_rx_s;
  logic                   r_rx_d;
  logic [CW-1:0]          r_baud_cnt;
  logic [3:0]             r_bit_cnt;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_perr;
  logic                   r_ferr;

  logic                   w_fall;
  logic                   w_wrap;
  logic                   w_sample;

  assign w_fall   = r_rx_d & ~r_rx_s;
  assign w_wrap   = (r_baud_cnt == C_LAST);
  assign w_sample = (r_baud_cnt == C_HALF);
  assign busy     = (r_state != S_IDLE);

  // Synchroniser resets high so an idle line never looks like a start edge.
  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
      r_rx_d    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
      r_rx_d    <= r_rx_s;
    end
  end

  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_next = S_START;
        end
      end
      S_START: begin
        if (w_sample && r_rx_s) begin
          w_next = S_IDLE;
        end else if (w_wrap) begin
          w_next = S_DATA;
        end
      end
      S_DATA: begin
        if (w_wrap && (r_bit_cnt == C_DATA_LAST)) begin
          w_next = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (w_wrap) begin
          w_next = S_STOP;
        end
      end
      S_STOP: begin
        // Leave mid final stop bit so a following start edge is not missed.
        if (w_sample && (r_bit_cnt == C_STOP_LAST)) begin
          w_next = S_IDLE;
          w_done = 1'b1;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      r_baud_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_perr     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) || w_wrap) begin
        r_baud_cnt <= '0;
      end else begin
        r_baud_cnt <= r_baud_cnt + 1'b1;
      end

      case (r_state)
        S_DATA: begin
          if (w_sample) begin
            r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
          end
          if (w_wrap) begin
            r_bit_cnt <= (r_bit_cnt == C_DATA_LAST) ? 4'd0 : r_bit_cnt + 4'd1;
          end
        end
        S_PARITY: begin
          if (w_sample) begin
            r_perr <= (^r_shift) ^ r_rx_s ^ C_ODD;
          end
        end
        S_STOP: begin
          if (w_sample && !r_rx_s) begin
            r_ferr <= 1'b1;
          end
          if (w_wrap) begin
            r_bit_cnt <= r_bit_cnt + 4'd1;
          end
        end
        default: begin
          r_bit_cnt <= '0;
          r_perr    <= 1'b0;
          r_ferr    <= 1'b0;
        end
      endcase
    end
  end

  // Final stop sample is folded in directly; r_ferr only covers earlier stop bits.
  always_ff @(posedge system_clk or negedge system_rst_n) begin
    if (!system_rst_n) begin
      po_data       <= '0;
      po_flag       <= 1'b0;
      po_parity_err <= 1'b0;
      po_frame_err  <= 1'b0;
    end else begin
      po_flag <= w_done;
      if (w_done) begin
        po_data       <= r_shift;
        po_parity_err <= r_perr;
        po_frame_err  <= r_ferr | ~r_rx_s;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - randomized scoreboard bench for uart_rx_param in three configurations
module tb_uart_rx_param;

  localparam int CLK_HZ = 50000000;
  localparam int BPS_A  = 5000000;
  localparam int BPS_C  = 4000000;
  localparam int MAX_A  = CLK_HZ / BPS_A;
  localparam int MAX_C  = CLK_HZ / BPS_C;

  typedef struct packed {
    logic [8:0]  data;
    logic        perr;
    logic        ferr;
    logic [31:0] cyc;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_a, rx_b, rx_c;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic       flag_a, flag_b, flag_c;
  logic       perr_a, perr_b, perr_c;
  logic       ferr_a, ferr_b, ferr_c;
  logic       busy_a, busy_b, busy_c;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;
  rec_t got_q[3][$];
  rec_t exp_q[3][$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx_param #(.CLK_FREQ(CLK_HZ), .UART_BPS(BPS_A), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .system_clk(clk), .system_rst_n(rst_n), .rx(rx_a), .po_data(data_a), .po_flag(flag_a),
    .po_parity_err(perr_a), .po_frame_err(ferr_a), .busy(busy_a));

  uart_rx_param #(.CLK_FREQ(CLK_HZ), .UART_BPS(BPS_A), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .system_clk(clk), .system_rst_n(rst_n), .rx(rx_b), .po_data(data_b), .po_flag(flag_b),
    .po_parity_err(perr_b), .po_frame_err(ferr_b), .busy(busy_b));

  uart_rx_param #(.CLK_FREQ(CLK_HZ), .UART_BPS(BPS_C), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_c (
    .system_clk(clk), .system_rst_n(rst_n), .rx(rx_c), .po_data(data_c), .po_flag(flag_c),
    .po_parity_err(perr_c), .po_frame_err(ferr_c), .busy(busy_c));

  always @(negedge clk) begin
    if (flag_a) got_q[0].push_back({1'b0, data_a, perr_a, ferr_a, 32'(cyc)});
    if (flag_b) got_q[1].push_back({1'b0, data_b, perr_b, ferr_b, 32'(cyc)});
    if (flag_c) got_q[2].push_back({2'b00, data_c, perr_c, ferr_c, 32'(cyc)});
  end

  function automatic int max_of(input int w);
    return (w == 2) ? MAX_C : MAX_A;
  endfunction
  function automatic int nb_of(input int w);
    return (w == 2) ? 7 : 8;
  endfunction
  function automatic int pm_of(input int w);
    return (w == 0) ? 0 : ((w == 1) ? 2 : 1);
  endfunction
  function automatic int ns_of(input int w);
    return (w == 2) ? 2 : 1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input int w, input logic v);
    case (w)
      0: rx_a = v;
      1: rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Expected result comes from the frame as placed on the line: masked data,
  // parity rule on the count of ones, any low stop bit, and mid-stop latency.
  task automatic send(input int w, input logic [8:0] d, input logic pbit, input logic [1:0] stops);
    int mx, nb, pm, ns, ones;
    logic [8:0] dm;
    rec_t e;
    mx = max_of(w);
    nb = nb_of(w);
    pm = pm_of(w);
    ns = ns_of(w);
    dm = d & 9'((1 << nb) - 1);
    ones = $countones(dm) + int'(pbit);
    e.data = dm;
    e.perr = (pm == 0) ? 1'b0 : ((pm == 1) ? (ones % 2 != 1) : (ones % 2 != 0));
    e.ferr = (stops[0] == 1'b0) || ((ns == 2) && (stops[1] == 1'b0));
    e.cyc  = 32'(cyc + (nb + int'(pm != 0) + ns) * mx + mx / 2 + 4);
    exp_q[w].push_back(e);
    drive(w, 1'b0);
    wait_n(mx);
    for (int i = 0; i < nb; i++) begin
      drive(w, d[i]);
      wait_n(mx);
    end
    if (pm != 0) begin
      drive(w, pbit);
      wait_n(mx);
    end
    for (int i = 0; i < ns; i++) begin
      drive(w, stops[i]);
      wait_n(mx);
    end
  endtask

  task automatic drain(input int w, input string tag);
    rec_t g, e;
    int k;
    check($sformatf("%s flag count", tag), 32'(got_q[w].size()), 32'(exp_q[w].size()));
    k = 0;
    while (got_q[w].size() > 0 && exp_q[w].size() > 0) begin
      g = got_q[w].pop_front();
      e = exp_q[w].pop_front();
      check($sformatf("%s[%0d] data", tag, k), 32'(g.data), 32'(e.data));
      check($sformatf("%s[%0d] parity_err", tag, k), 32'(g.perr), 32'(e.perr));
      check($sformatf("%s[%0d] frame_err", tag, k), 32'(g.ferr), 32'(e.ferr));
      check($sformatf("%s[%0d] flag cycle", tag, k), g.cyc, e.cyc);
      k++;
    end
    got_q[w].delete();
    exp_q[w].delete();
  endtask

  initial begin
    logic       seen_busy;
    logic [8:0] d;
    rst_n = 1'b0;
    rx_a = 1'b1;
    rx_b = 1'b1;
    rx_c = 1'b1;
    wait_n(3);
    check("reset a", {24'd0, data_a, flag_a, perr_a, ferr_a, busy_a}, 32'd0);
    check("reset b", {24'd0, data_b, flag_b, perr_b, ferr_b, busy_b}, 32'd0);
    check("reset c", {25'd0, data_c, flag_c, perr_c, ferr_c, busy_c}, 32'd0);
    rst_n = 1'b1;
    wait_n(4);

    for (int i = 0; i < 8; i++) begin
      send(0, 9'($urandom_range(0, 255)), 1'b0, 2'b11);
    end
    wait_n(2 * MAX_A);
    drain(0, "8n1 burst");

    send(1, 9'h0A5, 1'b0, 2'b11);
    send(1, 9'h0A5, 1'b1, 2'b11);
    for (int i = 0; i < 6; i++) begin
      send(1, 9'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 2'b11);
    end
    wait_n(2 * MAX_A);
    drain(1, "even parity");

    send(2, 9'h03C, 1'b1, 2'b11);
    wait_n(2 * MAX_C);
    send(2, 9'h03C, 1'b1, 2'b01);
    drive(2, 1'b1);
    wait_n(2 * MAX_C);
    for (int i = 0; i < 6; i++) begin
      send(2, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      drive(2, 1'b1);
      wait_n(2 * MAX_C);
    end
    drain(2, "7o2");
    check("idle b after c traffic", 32'(got_q[1].size()), 32'd0);

    drive(0, 1'b0);
    wait_n(MAX_A / 2 - 2);
    drive(0, 1'b1);
    seen_busy = 1'b0;
    for (int i = 0; i < 3 * MAX_A; i++) begin
      @(negedge clk);
      seen_busy = seen_busy | busy_a;
    end
    check("glitch busy seen", 32'(seen_busy), 32'd1);
    check("glitch back idle", 32'(busy_a), 32'd0);
    drain(0, "glitch");

    send(0, 9'h000, 1'b0, 2'b00);
    wait_n(20 * MAX_A);
    drive(0, 1'b1);
    wait_n(2 * MAX_A);
    drain(0, "break");
    send(0, 9'h05A, 1'b0, 2'b11);
    wait_n(2 * MAX_A);
    drain(0, "after break");

    d = 9'($urandom_range(0, 255));
    drive(0, 1'b0);
    wait_n(MAX_A);
    for (int i = 0; i < 5; i++) begin
      drive(0, d[i]);
      wait_n((i == 4) ? MAX_A / 2 : MAX_A);
    end
    check("busy mid data", 32'(busy_a), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset mid frame a", {24'd0, data_a, flag_a, perr_a, ferr_a, busy_a}, 32'd0);
    drive(0, 1'b1);
    wait_n(3);
    rst_n = 1'b1;
    wait_n(2 * MAX_A);
    send(0, 9'h0C3, 1'b0, 2'b11);
    wait_n(2 * MAX_A);
    drain(0, "after reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
